// File: rtl/pipe_elastic_if.sv
// pipe_elastic_if -- handshake bundle for the elastic pipeline.
//   in_data/in_valid/in_ready    : upstream word, offer, accept
//   out_data/out_valid/out_ready : downstream word, offer, consume
//   count                        : number of occupied stages (0..H)
// Modports:
//   master : the environment (drives the upstream side and out_ready)
//   slave  : the pipeline itself
interface pipe_elastic_if #(
  parameter int H = 3,
  parameter int W = 32
) ();
  localparam int CW = $clog2(H + 1);

  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/pipe_elastic.sv
// pipe_elastic -- H-stage elastic pipeline with bubble collapse.
// Each stage holds a W-bit word and a valid bit. A word advances whenever
// the next stage is vacated, so bubbles close up even while the output is
// stalled. The ready path runs combinationally from out_ready back to
// in_ready, which gives full throughput with no skid stage.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (clears valid, data and count)
//   flush : synchronous discard of all words (data registers untouched)
//   bus   : pipe_elastic_if.slave handshake bundle (see interface file)
module pipe_elastic #(
  parameter int H = 3,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  pipe_elastic_if.slave  bus
);
  localparam int CW = $clog2(H + 1);

  logic [W-1:0]  data_q [H];
  logic [H-1:0]  valid_q;
  logic [CW-1:0] count_q;

  // vac[i]: stage i will be empty or passing its word on at the next edge.
  logic [H-1:0]  vac;
  logic          in_xfer;
  logic          out_xfer;

  // A stage is vacated if it, or any stage downstream of it, is empty, or
  // if the output is being consumed. Accumulating from the output end keeps
  // this a simple prefix-OR with no feedback through the vector.
  always_comb begin : vacate_chain
    logic hole;
    // NOTE: every combinational output gets a default before any branch or
    // loop touches it; leaving one unassigned on some path infers a latch.
    vac  = '0;
    hole = bus.out_ready;
    for (int i = H - 1; i >= 0; i--) begin
      hole   = hole | ~valid_q[i];
      vac[i] = hole;
    end
  end

  assign bus.in_ready = vac[0] & ~flush & ~reset;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = valid_q[H-1] & bus.out_ready;

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its upstream neighbour's pre-edge value; with blocking
  // assignments a word would ripple through several stages in one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      // NOTE: the data registers are cleared on reset as well, so out_data
      // reads 0 afterwards; this costs a reset net on every data flop and
      // would not be done for a RAM-based store.
      for (int i = 0; i < H; i++) data_q[i] <= '0;
    end else if (flush) begin
      // Only the valid bits go; data stays so flush is cheap.
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = H - 1; i >= 1; i--) begin
        if (vac[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
      if (vac[0]) valid_q[0] <= in_xfer;
      if (in_xfer) data_q[0] <= bus.in_data;
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  assign bus.out_data  = data_q[H-1];
  assign bus.out_valid = valid_q[H-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_pipe_elastic.sv
// tb_pipe_elastic -- self-checking bench for pipe_elastic (H=3, W=32).
// Directed table vectors and hand-written sequences cover latency,
// backpressure, streaming, bubble collapse, flush and reset; a randomized
// phase compares against a queue-of-words model in which each word tracks
// its stage position and advances when a slot ahead of it is free.
module tb_pipe_elastic;
  localparam int H = 3;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  pipe_elastic_if #(.H(H), .W(W)) bus ();

  pipe_elastic #(.H(H), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 2
  // units later, well away from the next edge.
  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic rs);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rs;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] word;
    int          pos;
  } ent_t;
  ent_t q[$];  // oldest word first

  function automatic logic m_ov();
    return (q.size() > 0) && (q[0].pos == H - 1);
  endfunction

  // Stage 0 can take a word if any slot is free or the head is leaving.
  function automatic logic m_ir(input logic ordy, input logic fl, input logic rs);
    return !fl && !rs && ((q.size() < H) || ordy);
  endfunction

  task automatic m_edge(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic rs);
    ent_t nq[$];
    logic ox, ix;
    if (rs || fl) begin
      q.delete();
      return;
    end
    ox = m_ov() && ordy;
    ix = iv && m_ir(ordy, fl, rs);
    for (int k = 0; k < q.size(); k++) begin
      ent_t e;
      e = q[k];
      if (k == 0 && ox) continue;
      // k words sit ahead of this one in the H-1-pos slots downstream.
      if (ox || (k < H - 1 - e.pos)) e.pos++;
      nq.push_back(e);
    end
    if (ix) nq.push_back('{word: d, pos: 0});
    q = nq;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    int          cnt;
  } vec_t;
  vec_t vt[14];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // single word latency: accept at edge 1, visible after edge 3, one cycle
    vt[0]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0,        0};
    vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1};
    vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0};
    // backpressure: 1,2,3 fill the pipe, 4 waits until out_ready rises
    vt[5]  = '{1'b1, 32'd1,        1'b0, 1'b1, 1'b0, 32'h0,        0};
    vt[6]  = '{1'b1, 32'd2,        1'b0, 1'b1, 1'b0, 32'h0,        1};
    vt[7]  = '{1'b1, 32'd3,        1'b0, 1'b1, 1'b0, 32'h0,        2};
    vt[8]  = '{1'b1, 32'd4,        1'b0, 1'b0, 1'b1, 32'd1,        3};
    vt[9]  = '{1'b1, 32'd4,        1'b1, 1'b1, 1'b1, 32'd1,        3};
    vt[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd2,        3};
    vt[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd3,        2};
    vt[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd4,        1};
    vt[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0};

    // ---- reset ----
    tick();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    check("ir_during_reset", 32'(bus.in_ready), 0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("ov_after_reset", 32'(bus.out_valid), 0);
    check("od_after_reset", bus.out_data, 0);
    check("cnt_after_reset", 32'(bus.count), 0);
    tick();

    // ---- table ----
    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy, 1'b0, 1'b0);
      check($sformatf("tbl%0d_ir", i), 32'(bus.in_ready), 32'(vt[i].ir));
      check($sformatf("tbl%0d_ov", i), 32'(bus.out_valid), 32'(vt[i].ov));
      if (vt[i].ov) check($sformatf("tbl%0d_od", i), bus.out_data, vt[i].od);
      check($sformatf("tbl%0d_cnt", i), 32'(bus.count), vt[i].cnt);
      tick();
    end

    // ---- streaming 1..10 ----
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, 32'(c + 1), 1'b1, 1'b0, 1'b0);
      check($sformatf("str%0d_ir", c), 32'(bus.in_ready), 1);
      if (c >= 3 && c <= 12) begin
        check($sformatf("str%0d_ov", c), 32'(bus.out_valid), 1);
        check($sformatf("str%0d_od", c), bus.out_data, 32'(c - 2));
      end else begin
        check($sformatf("str%0d_ov", c), 32'(bus.out_valid), 0);
      end
      if (c == 9) check("str_cnt_steady", 32'(bus.count), 3);
      tick();
    end

    // ---- bubble collapse: 7, two idle cycles, 8, out_ready low ----
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("bub_ov", 32'(bus.out_valid), 1);
    check("bub_od", bus.out_data, 32'd7);
    check("bub_cnt", 32'(bus.count), 2);
    tick();
    // 8 must already sit in the middle stage: it follows 7 immediately.
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("bub_out7", bus.out_data, 32'd7);
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("bub_ov8", 32'(bus.out_valid), 1);
    check("bub_out8", bus.out_data, 32'd8);
    check("bub_cnt8", 32'(bus.count), 1);
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("bub_empty", 32'(bus.out_valid), 0);
    tick();

    // ---- flush with a word offered ----
    drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
    check("fl_cnt_before", 32'(bus.count), 3);
    check("fl_ir", 32'(bus.in_ready), 0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_ov", 32'(bus.out_valid), 0);
    check("fl_cnt", 32'(bus.count), 0);
    check("fl_data_kept", bus.out_data, 32'hA1);
    check("fl_ir_after", 32'(bus.in_ready), 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check($sformatf("fl_nothing%0d", c), 32'(bus.out_valid), 0);
      tick();
    end

    // ---- reset mid-stream ----
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h99, 1'b1, 1'b1, 1'b1);
    check("rs_full_cnt", 32'(bus.count), 3);
    check("rs_ir", 32'(bus.in_ready), 0);
    tick();
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 32'h55, 1'b1, 1'b0, 1'b0);
      if (c == 0) begin
        check("rs_od0", bus.out_data, 0);
        check("rs_cnt0", 32'(bus.count), 0);
        check("rs_ir_after", 32'(bus.in_ready), 1);
      end
      if (c == 3) begin
        check("rs_ov55", 32'(bus.out_valid), 1);
        check("rs_od55", bus.out_data, 32'h55);
      end else begin
        check($sformatf("rs_ov%0d", c), 32'(bus.out_valid), 0);
      end
      tick();
    end

    // ---- randomized against the model ----
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      logic        iv, ordy, fl, rs;
      logic [31:0] d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      d    = $urandom();
      drive(iv, d, ordy, fl, rs);
      check("rnd_ir", 32'(bus.in_ready), 32'(m_ir(ordy, fl, rs)));
      check("rnd_ov", 32'(bus.out_valid), 32'(m_ov()));
      if (m_ov()) check("rnd_od", bus.out_data, q[0].word);
      check("rnd_cnt", 32'(bus.count), 32'(q.size()));
      m_edge(iv, d, ordy, fl, rs);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_elastic.md
PIPE_ELASTIC -- requirements
Module: pipe_elastic

Interface
REQ-001 Parameter H, default 3, number of pipeline stages (H >= 2).
REQ-002 Parameter W, default 32, data width in bits.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port flush  input  1  synchronous discard of all pipeline contents.
REQ-006 Port in_data  input  W  upstream data word.
REQ-007 Port in_valid  input  1  upstream offers in_data this cycle.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port out_data  output  W  data held in stage H-1.
REQ-010 Port out_valid  output  1  stage H-1 holds a valid word.
REQ-011 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 Port count  output  clog2(H+1)  number of valid stages, range 0..H.

Function
REQ-013 The block SHALL hold H stages S[0]..S[H-1], each with a W-bit data register and a valid bit; S[0] is the input end, S[H-1] drives out_data and out_valid directly from registers.
REQ-014 A transfer SHALL occur on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready, both at the rising edge of clk.
REQ-015 S[H-1] SHALL be vacated when it is empty or an output transfer occurs; S[i] for i < H-1 SHALL be vacated when it is empty or it moves into S[i+1].
REQ-016 S[i+1] SHALL load S[i] (data and valid) when S[i] is valid and S[i+1] is vacated; otherwise S[i+1] SHALL hold, or clear its valid bit if it was vacated by a move and receives nothing.
REQ-017 in_ready SHALL equal (S[0] vacated) && !flush && !reset; S[0] SHALL load in_data on an input transfer.
REQ-018 Bubbles SHALL collapse: a valid word SHALL advance one stage per cycle whenever the next stage is vacated, regardless of out_ready.
REQ-019 Latency: a word accepted at edge k into an empty pipe SHALL appear with out_valid=1 after edge k+H-1 (H edges including the accepting edge).
REQ-020 Throughput: with out_ready held at 1 and in_valid held at 1, the block SHALL accept and emit one word per cycle in steady state.
REQ-021 Order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-022 Full: with all H stages valid and out_ready=0, in_ready SHALL be 0 and all stages SHALL hold.
REQ-023 Full, with out_ready=1: in_ready SHALL be 1 in the same cycle (combinational ready path), and the output and input transfers SHALL occur at the same edge.
REQ-024 count SHALL be a register equal to the number of valid stages, updated as count + in_xfer - out_xfer; simultaneous in/out transfers SHALL leave count unchanged.
REQ-025 flush=1 SHALL clear all valid bits and count at the next edge; an output transfer in that cycle counts as consumed, and no input is accepted (in_ready=0).
REQ-026 flush SHALL leave the data registers unchanged.

Reset
REQ-027 On reset=1 at an edge, all valid bits, all data registers, and count SHALL become 0; reset takes priority over flush and all transfers.
REQ-028 While reset=1, in_ready SHALL be 0; after reset deasserts, in_ready SHALL be 1 and out_valid 0 until the first word arrives.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; no word accepted before reset SHALL appear at the output afterwards.

Verification
REQ-030 Latency: H=3, empty pipe, out_ready=1, one word 0xA5A5A5A5 at edge 1 -> out_valid=1 and out_data=0xA5A5A5A5 after edge 3, for exactly one cycle; count goes 1,1,1,0.
REQ-031 Streaming: in_valid=1 and out_ready=1 with words 1..10 -> outputs 1..10 in consecutive cycles starting after edge 3; in_ready stays 1; count settles at 3.
REQ-032 Backpressure: out_ready=0, push words 1,2,3,4 -> first 3 accepted, in_ready=0 while 4 is offered, count=3; raise out_ready -> 1,2,3,4 emitted in order, with no loss.
REQ-033 Bubble collapse: push 7, idle 2 cycles, push 8, with out_ready=0 -> after settling, S[2]=7, S[1]=8, count=2.
REQ-034 Flush: pipe holds 3 words, flush=1 with in_valid=1 for one cycle -> next cycle out_valid=0, count=0, and the offered word is not accepted.
REQ-035 Reset mid-stream: full pipe, reset=1 for one cycle -> out_valid=0, out_data=0, count=0; after a new push of 0x55, exactly 0x55 emerges after 3 edges.
